// File: rtl/led_matrix_driver_pkg.sv
// Shared definitions for the LED matrix display path: scan state encoding and
// default matrix geometry used by the frame source and the pin driver.
package led_matrix_driver_pkg;

  localparam int unsigned LED_N_ROWS  = 16;
  localparam int unsigned LED_N_COLS  = 16;
  localparam int unsigned LED_FRAME_W = LED_N_ROWS * LED_N_COLS;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/led_matrix_driver.sv
// Latches a full frame into a shadow register and multiplexes it row by row onto
// the matrix pins, with an all-off blanking gap before every row.
module led_matrix_driver
  import led_matrix_driver_pkg::*;
#(
  parameter int unsigned N_ROWS         = LED_N_ROWS,
  parameter int unsigned N_COLS         = LED_N_COLS,
  parameter int unsigned DWELL_CYCLES   = 1000,
  parameter int unsigned BLANK_CYCLES   = 8,
  parameter int unsigned ROW_ACTIVE_LOW = 1,
  parameter int unsigned COL_ACTIVE_LOW = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_ROWS*N_COLS-1:0]   frame,
  input  logic                       frame_valid,
  output logic                       frame_ready,
  output logic [N_ROWS-1:0]          row_sel,
  output logic [N_COLS-1:0]          col_data,
  output logic                       frame_start
);

  localparam int unsigned FW   = N_ROWS * N_COLS;
  localparam int unsigned RW   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [N_ROWS-1:0] ROW_OFF = (ROW_ACTIVE_LOW != 0) ? {N_ROWS{1'b1}} : '0;
  localparam logic [N_COLS-1:0] COL_INV = (COL_ACTIVE_LOW != 0) ? {N_COLS{1'b1}} : '0;

  scan_state_e        state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [FW-1:0]      shadow_q, shadow_d;
  logic               taken_q, taken_d;
  logic               frame_ready_q, frame_ready_d;
  logic               frame_start_q, frame_start_d;
  logic [N_ROWS-1:0]  row_sel_q, row_sel_d;
  logic [N_COLS-1:0]  col_data_q, col_data_d;
  logic               accept_c;
  logic [N_COLS-1:0]  row_bits_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BLANK;
      row_q         <= '0;
      timer_q       <= '0;
      shadow_q      <= '0;
      taken_q       <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_start_q <= 1'b0;
      row_sel_q     <= ROW_OFF;
      col_data_q    <= COL_INV;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      timer_q       <= timer_d;
      shadow_q      <= shadow_d;
      taken_q       <= taken_d;
      frame_ready_q <= frame_ready_d;
      frame_start_q <= frame_start_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
    end
  end

  // Scan sequencing, frame capture window and pin drive (pins lag state by one cycle).
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    timer_d       = timer_q + TW'(1);
    shadow_d      = shadow_q;
    taken_d       = taken_q;
    frame_ready_d = 1'b0;
    frame_start_d = 1'b0;
    row_sel_d     = ROW_OFF;
    col_data_d    = COL_INV;
    accept_c      = frame_valid && frame_ready_q;
    row_bits_c    = N_COLS'(shadow_q >> (int'(row_q) * N_COLS));

    unique case (state_q)
      BLANK: begin
        if (timer_q == TW'(BLANK_CYCLES - 1)) begin
          state_d = SHOW;
          timer_d = '0;
        end
      end
      SHOW: begin
        if (timer_q == TW'(DWELL_CYCLES - 1)) begin
          state_d = BLANK;
          timer_d = '0;
          row_d   = (row_q == RW'(N_ROWS - 1)) ? '0 : row_q + RW'(1);
        end
      end
    endcase

    // A capture on the last blank cycle still lands before row 0 is lit.
    if (accept_c) begin
      shadow_d = frame;
      taken_d  = 1'b1;
    end else if (state_d == SHOW) begin
      taken_d  = 1'b0;
    end

    frame_ready_d = (state_d == BLANK) && (row_d == '0) && !taken_d;

    if (state_q == SHOW) begin
      row_sel_d     = ROW_OFF ^ (N_ROWS'(1) << row_q);
      col_data_d    = row_bits_c ^ COL_INV;
      frame_start_d = (row_q == '0) && (timer_q == '0);
    end
  end

  assign frame_ready = frame_ready_q;
  assign frame_start = frame_start_q;
  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;

endmodule

// File: tb/tb_led_matrix_driver.sv
// Randomized bench for led_matrix_driver: a phase-arithmetic scan model is checked
// against the pins every cycle, plus literal checks of key display scenarios.
module tb_led_matrix_driver;

  localparam int unsigned NR = 16;
  localparam int unsigned NC = 16;
  localparam int unsigned FW = NR * NC;
  localparam int unsigned DW = 4;
  localparam int unsigned BW = 2;
  localparam int unsigned SLOT = DW + BW;
  localparam int unsigned P  = NR * SLOT;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] frame;
  logic          frame_valid;
  logic          frame_ready;
  logic [NR-1:0] row_sel;
  logic [NC-1:0] col_data;
  logic          frame_start;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_matrix_driver #(
    .N_ROWS(NR), .N_COLS(NC), .DWELL_CYCLES(DW), .BLANK_CYCLES(BW),
    .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .row_sel(row_sel), .col_data(col_data),
    .frame_start(frame_start)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t counts edges since the last reset edge; scan position is pure phase arithmetic.
  int            t;
  bit            live = 1'b0;
  bit            taken;
  bit            m_ready;
  logic [FW-1:0] m_shadow;
  logic [NR-1:0] e_row;
  logic [NC-1:0] e_col;
  bit            e_start;

  always @(posedge clk) begin
    logic          s_rst;
    logic          s_valid;
    logic [FW-1:0] s_frame;
    int            ph;
    int            r;
    bit            show;
    s_rst   = rst;
    s_valid = frame_valid;
    s_frame = frame;
    #1;
    if (s_rst) begin
      live = 1'b1; t = 0; taken = 1'b0; m_ready = 1'b0; m_shadow = '0;
      e_row = '1; e_col = '0; e_start = 1'b0;
    end else if (live) begin
      ph    = t % P;
      r     = ph / SLOT;
      show  = (ph % SLOT) >= BW;
      e_row   = show ? ~(NR'(1) << r) : '1;
      e_col   = show ? NC'(m_shadow >> (r * NC)) : '0;
      e_start = show && (r == 0) && ((ph % SLOT) == BW);
      if (s_valid && m_ready) begin
        m_shadow = s_frame;
        taken    = 1'b1;
      end
      t = t + 1;
      if ((t % P) >= BW) taken = 1'b0;
      m_ready = ((t % P) < BW) && !taken;
    end
    if (live) begin
      chk("row_sel", 32'(row_sel), 32'(e_row));
      chk("col_data", 32'(col_data), 32'(e_col));
      chk("frame_ready", 32'(frame_ready), 32'(m_ready));
      chk("frame_start", 32'(frame_start), 32'(e_start));
      chk("onehot0_rows", 32'($onehot0(~row_sel)), 32'd1);
    end
  end

  task automatic wait_row(input int r);
    logic [NR-1:0] want;
    int n;
    want = ~(NR'(1) << r);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (row_sel !== want && n < 400);
    if (row_sel !== want) begin
      checks++; failures++;
      $display("FAIL wait_row%0d: timeout, row_sel %h expected %h", r, row_sel, want);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (frame_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (frame_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL wait_ready: timeout, frame_ready %b expected 1", frame_ready);
    end
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  initial begin
    logic [FW-1:0] cb;
    int n;
    rst = 1'b1; frame_valid = 1'b0; frame = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Empty scan: frame_start period
    n = 0;
    while (frame_start !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (frame_start !== 1'b1 && n < 300);
    chk("start_period", 32'(n), 32'(P));
    repeat (50) @(negedge clk);

    // Checkerboard frame
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) cb[r*NC + c] = 1'((r + c) & 1);
    frame = cb; frame_valid = 1'b1;
    wait_ready();
    @(negedge clk) frame_valid = 1'b0;
    wait_row(0); chk("cb_row0", 32'(col_data), 32'h0000_AAAA);
    wait_row(1); chk("cb_row1", 32'(col_data), 32'h0000_5555);

    // Mid-frame update must wait for the next refresh
    wait_row(7);
    frame = '1; frame_valid = 1'b1;
    wait_row(8); chk("old_row8", 32'(col_data), 32'h0000_AAAA);
    chk("no_ready_mid", 32'(frame_ready), 32'd0);
    wait_ready();
    @(negedge clk) frame_valid = 1'b0;
    wait_row(0);  chk("ones_row0", 32'(col_data), 32'h0000_FFFF);
    wait_row(15); chk("ones_row15", 32'(col_data), 32'h0000_FFFF);

    // Valid pulse outside window is ignored
    wait_row(4);
    frame = rand_frame(); frame_valid = 1'b1;
    @(negedge clk) frame_valid = 1'b0;
    frame = '1;
    wait_row(0); chk("ignored_pulse", 32'(col_data), 32'h0000_FFFF);

    // Reset in the middle of row 9
    wait_row(9);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rows_off", 32'(row_sel), 32'h0000_FFFF);
    chk("rst_cols_off", 32'(col_data), 32'd0);
    chk("rst_ready", 32'(frame_ready), 32'd0);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (row_sel !== 16'hFFFE && n < 50);
    chk("rst_to_row0", 32'(n), 32'(BW + 1));
    chk("rst_shadow", 32'(col_data), 32'd0);

    // Randomized source traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        frame = rand_frame(); frame_valid = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        frame_valid = 1'b0;
      end
    end
    frame_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
